// File: rtl/stream_demux_qos_if.sv
// -----------------------------------------------------------------------------
// stream_demux_qos_if
//   Bundles the merged input stream and the fanned-out output streams of the
//   packet demultiplexer.
//
//   master : environment side (drives the input beat and the per-output ready).
//   slave  : demultiplexer side (drives s_ready_o and all m_*_o outputs).
//
//   s_data_i / s_qos_i / s_id_i / s_last_i / s_valid_i : input beat
//   s_ready_o                                          : input ready
//   m_data_o / m_qos_o   [STREAM_COUNT] : broadcast beat data and QoS
//   m_last_o / m_valid_o [STREAM_COUNT] : per-output last and valid
//   m_ready_i            [STREAM_COUNT] : per-output ready
// -----------------------------------------------------------------------------
interface stream_demux_qos_if #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT)
);
  logic [T_DATA_WIDTH-1:0] s_data_i;
  logic [T_QOS__WIDTH-1:0] s_qos_i;
  logic [T_ID___WIDTH-1:0] s_id_i;
  logic                    s_last_i;
  logic                    s_valid_i;
  logic                    s_ready_o;

  logic [T_DATA_WIDTH-1:0] m_data_o [STREAM_COUNT];
  logic [T_QOS__WIDTH-1:0] m_qos_o  [STREAM_COUNT];
  logic [STREAM_COUNT-1:0] m_last_o;
  logic [STREAM_COUNT-1:0] m_valid_o;
  logic [STREAM_COUNT-1:0] m_ready_i;

  modport master (
    output s_data_i, s_qos_i, s_id_i, s_last_i, s_valid_i,
    input  s_ready_o,
    input  m_data_o, m_qos_o, m_last_o, m_valid_o,
    output m_ready_i
  );

  modport slave (
    input  s_data_i, s_qos_i, s_id_i, s_last_i, s_valid_i,
    output s_ready_o,
    output m_data_o, m_qos_o, m_last_o, m_valid_o,
    input  m_ready_i
  );
endinterface

// File: rtl/stream_demux_qos.sv
// -----------------------------------------------------------------------------
// stream_demux_qos
//   Packet-level 1-to-N stream demultiplexer. The destination id is captured
//   on each packet's head beat and every beat of that packet is forwarded to
//   the selected output through a one-beat output register. QoS passes through
//   unchanged. Packets whose head id names no existing output are consumed
//   and counted in a saturating drop counter.
//
//   clk_i      : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : stream_demux_qos_if.slave (input stream + output streams)
//   drop_cnt_o : saturating count of packets dropped for an invalid id
// -----------------------------------------------------------------------------
module stream_demux_qos #(
  parameter int T_DATA_WIDTH   = 8,
  parameter int T_QOS__WIDTH   = 4,
  parameter int STREAM_COUNT   = 2,
  parameter int T_ID___WIDTH   = $clog2(STREAM_COUNT),
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  stream_demux_qos_if.slave         bus,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  typedef enum logic [1:0] {HEAD, BODY, DROP} state_t;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + DROP_CNT_WIDTH'(1);
  endfunction

  state_t                  state, state_n;
  logic [T_ID___WIDTH-1:0] dest_reg;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;

  logic                    vld_p1;
  logic [T_ID___WIDTH-1:0] buf_dest_p1;
  logic [T_DATA_WIDTH-1:0] buf_data_p1;
  logic [T_QOS__WIDTH-1:0] buf_qos_p1;
  logic                    buf_last_p1;

  logic                    ready_sel;
  logic                    buf_free;
  logic                    s_ready;
  logic                    hs_p0;
  logic                    id_ok_p0;
  logic                    load_p0;
  logic [T_ID___WIDTH-1:0] load_dest_p0;
  logic                    drop_inc_p0;

  // ---- stage p0: input decode, routing FSM ----------------------------------
  // When every id value names an output the range check is always true, so it
  // is elided to avoid a constant comparison.
  if (STREAM_COUNT == (1 << T_ID___WIDTH)) begin : g_pow2
    assign id_ok_p0 = 1'b1;
  end else begin : g_npow2
    assign id_ok_p0 = (int'(bus.s_id_i) < STREAM_COUNT);
  end

  always_comb begin
    ready_sel = 1'b0;
    for (int k = 0; k < STREAM_COUNT; k++) begin
      if (buf_dest_p1 == T_ID___WIDTH'(k)) ready_sel = bus.m_ready_i[k];
    end
  end

  // Buffer can take a new beat if empty or draining this cycle.
  assign buf_free      = !vld_p1 | ready_sel;
  // DROP discards beats, so it never waits on the output side.
  assign s_ready       = (state == DROP) | buf_free;
  assign bus.s_ready_o = s_ready;
  assign hs_p0         = bus.s_valid_i & s_ready;

  always_comb begin
    state_n      = state;
    load_p0      = 1'b0;
    load_dest_p0 = dest_reg;
    drop_inc_p0  = 1'b0;
    case (state)
      HEAD: begin
        if (hs_p0) begin
          if (id_ok_p0) begin
            load_p0      = 1'b1;
            load_dest_p0 = bus.s_id_i;
            if (!bus.s_last_i) state_n = BODY;
          end else begin
            drop_inc_p0 = 1'b1;
            if (!bus.s_last_i) state_n = DROP;
          end
        end
      end
      BODY: begin
        if (hs_p0) begin
          load_p0 = 1'b1;
          if (bus.s_last_i) state_n = HEAD;
        end
      end
      DROP: begin
        if (hs_p0 && bus.s_last_i) state_n = HEAD;
      end
      default: state_n = HEAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HEAD;
      dest_reg <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      if (load_p0) dest_reg <= load_dest_p0;
      if (drop_inc_p0) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // ---- stage p1: output register --------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      buf_dest_p1 <= '0;
      buf_data_p1 <= '0;
      buf_qos_p1  <= '0;
      buf_last_p1 <= 1'b0;
    end else if (load_p0) begin
      vld_p1      <= 1'b1;
      buf_dest_p1 <= load_dest_p0;
      buf_data_p1 <= bus.s_data_i;
      buf_qos_p1  <= bus.s_qos_i;
      buf_last_p1 <= bus.s_last_i;
    end else if (ready_sel) begin
      vld_p1 <= 1'b0;
    end
  end

  always_comb begin
    for (int k = 0; k < STREAM_COUNT; k++) begin
      bus.m_valid_o[k] = vld_p1 & (buf_dest_p1 == T_ID___WIDTH'(k));
      bus.m_last_o[k]  = buf_last_p1 & vld_p1 & (buf_dest_p1 == T_ID___WIDTH'(k));
      bus.m_data_o[k]  = buf_data_p1;
      bus.m_qos_o[k]   = buf_qos_p1;
    end
  end

  assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_stream_demux_qos.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_qos
//   Directed bench for stream_demux_qos with three outputs (so id 3 is an
//   invalid destination) and a 3-bit drop counter (so saturation is reachable).
// -----------------------------------------------------------------------------
module tb_stream_demux_qos;
  localparam int DW  = 8;
  localparam int QW  = 4;
  localparam int SC  = 3;
  localparam int IW  = 2;
  localparam int DCW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DCW-1:0] drop_cnt;
  int             n_vec = 0;
  int             n_err = 0;

  stream_demux_qos_if #(
    .T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(SC), .T_ID___WIDTH(IW)
  ) bus ();

  stream_demux_qos #(
    .T_DATA_WIDTH(DW), .T_QOS__WIDTH(QW), .STREAM_COUNT(SC),
    .T_ID___WIDTH(IW), .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clk_i      (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .drop_cnt_o (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [IW-1:0] id, input logic [DW-1:0] data,
                       input logic [QW-1:0] qos, input logic last);
    bus.s_valid_i = 1'b1;
    bus.s_id_i    = id;
    bus.s_data_i  = data;
    bus.s_qos_i   = qos;
    bus.s_last_i  = last;
  endtask

  task automatic idle();
    bus.s_valid_i = 1'b0;
    bus.s_id_i    = '0;
    bus.s_data_i  = '0;
    bus.s_qos_i   = '0;
    bus.s_last_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.m_ready_i = 3'b111;
    for (int i = 0; i < 3; i++) begin
      drive(IW'(i), DW'(8'hF0 + i), 4'hF, i[0]);
      step();
      n_vec++;
      if (bus.m_valid_o !== 3'b000) begin
        n_err++; $display("FAIL reset_valid[%0d]: got %b expected 000", i, bus.m_valid_o);
      end
      n_vec++;
      if (bus.m_last_o !== 3'b000) begin
        n_err++; $display("FAIL reset_last[%0d]: got %b expected 000", i, bus.m_last_o);
      end
      n_vec++;
      if (drop_cnt !== 3'd0) begin
        n_err++; $display("FAIL reset_drop[%0d]: got %0d expected 0", i, drop_cnt);
      end
      n_vec++;
      if (bus.m_data_o[1] !== 8'h00 || bus.m_qos_o[2] !== 4'h0) begin
        n_err++; $display("FAIL reset_data[%0d]: got %h/%h expected 00/0", i,
                          bus.m_data_o[1], bus.m_qos_o[2]);
      end
    end
    idle();
    rst_n = 1'b1;
    step();
    n_vec++;
    if (bus.s_ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b expected 1", bus.s_ready_o);
    end
  endtask

  task automatic test_single_packet();
    logic [DW-1:0] beats [3];
    beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
    bus.m_ready_i = 3'b111;
    drive(2'd1, beats[0], 4'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (bus.m_valid_o !== 3'b010 || bus.m_data_o[1] !== beats[i] ||
          bus.m_qos_o[1] !== 4'd5) begin
        n_err++; $display("FAIL single_beat[%0d]: got v=%b d=%h q=%h expected v=010 d=%h q=5",
                          i, bus.m_valid_o, bus.m_data_o[1], bus.m_qos_o[1], beats[i]);
      end
      n_vec++;
      if (bus.m_last_o !== ((i == 2) ? 3'b010 : 3'b000)) begin
        n_err++; $display("FAIL single_last[%0d]: got %b expected %b", i, bus.m_last_o,
                          (i == 2) ? 3'b010 : 3'b000);
      end
      if (i < 2) drive(2'd1, beats[i+1], 4'd5, i == 1);
      else idle();
    end
    step();
    n_vec++;
    if (bus.m_valid_o !== 3'b000) begin
      n_err++; $display("FAIL single_drained: got %b expected 000", bus.m_valid_o);
    end
  endtask

  task automatic test_backpressure();
    bus.m_ready_i = 3'b110;
    drive(2'd0, 8'hB1, 4'd2, 1'b0);
    step();
    drive(2'd0, 8'hB2, 4'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (bus.s_ready_o !== 1'b0) begin
        n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, bus.s_ready_o);
      end
      n_vec++;
      if (bus.m_valid_o !== 3'b001 || bus.m_data_o[0] !== 8'hB1 ||
          bus.m_last_o !== 3'b000 || bus.m_qos_o[0] !== 4'd2) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b q=%h expected v=001 d=b1 l=000 q=2",
                          i, bus.m_valid_o, bus.m_data_o[0], bus.m_last_o, bus.m_qos_o[0]);
      end
      step();
    end
    bus.m_ready_i = 3'b111;
    step();
    n_vec++;
    if (bus.m_valid_o !== 3'b001 || bus.m_data_o[0] !== 8'hB2 || bus.m_last_o !== 3'b001) begin
      n_err++; $display("FAIL bp_b2: got v=%b d=%h l=%b expected v=001 d=b2 l=001",
                        bus.m_valid_o, bus.m_data_o[0], bus.m_last_o);
    end
    idle();
    step();
    n_vec++;
    if (bus.m_valid_o !== 3'b000) begin
      n_err++; $display("FAIL bp_drained: got %b expected 000", bus.m_valid_o);
    end
  endtask

  task automatic test_route_lock();
    logic [DW-1:0] beats [3];
    beats[0] = 8'hC1; beats[1] = 8'hC2; beats[2] = 8'hC3;
    bus.m_ready_i = 3'b111;
    drive(2'd0, beats[0], 4'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (bus.m_valid_o !== 3'b001 || bus.m_data_o[0] !== beats[i]) begin
        n_err++; $display("FAIL lock_beat[%0d]: got v=%b d=%h expected v=001 d=%h",
                          i, bus.m_valid_o, bus.m_data_o[0], beats[i]);
      end
      if (i < 2) drive(2'd1, beats[i+1], 4'd7, i == 1);
      else idle();
    end
    step();
  endtask

  task automatic test_invalid_id();
    bus.m_ready_i = 3'b111;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.s_ready_o !== 1'b1) begin
        n_err++; $display("FAIL drop_ready[%0d]: got %b expected 1", i, bus.s_ready_o);
      end
      drive(2'd3, DW'(8'hD1 + i), 4'd1, i == 3);
      step();
      n_vec++;
      if (bus.m_valid_o !== 3'b000 || drop_cnt !== 3'd1) begin
        n_err++; $display("FAIL drop_beat[%0d]: got v=%b cnt=%0d expected v=000 cnt=1",
                          i, bus.m_valid_o, drop_cnt);
      end
    end
    drive(2'd2, 8'hE1, 4'd3, 1'b1);
    step();
    n_vec++;
    if (bus.m_valid_o !== 3'b100 || bus.m_data_o[2] !== 8'hE1 || bus.m_last_o !== 3'b100 ||
        bus.m_qos_o[2] !== 4'd3 || drop_cnt !== 3'd1) begin
      n_err++; $display("FAIL drop_next: got v=%b d=%h l=%b q=%h cnt=%0d expected v=100 d=e1 l=100 q=3 cnt=1",
                        bus.m_valid_o, bus.m_data_o[2], bus.m_last_o, bus.m_qos_o[2], drop_cnt);
    end
    idle();
    step();
  endtask

  task automatic test_drop_saturate();
    logic [DCW-1:0] exp_cnt;
    bus.m_ready_i = 3'b111;
    for (int i = 0; i < 8; i++) begin
      drive(2'd3, 8'h55, 4'd0, 1'b1);
      step();
      exp_cnt = (i + 2 > 7) ? 3'd7 : DCW'(i + 2);
      n_vec++;
      if (drop_cnt !== exp_cnt || bus.m_valid_o !== 3'b000) begin
        n_err++; $display("FAIL sat_cnt[%0d]: got cnt=%0d v=%b expected cnt=%0d v=000",
                          i, drop_cnt, bus.m_valid_o, exp_cnt);
      end
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    bus.m_ready_i = 3'b111;
    drive(2'd0, 8'h61, 4'd4, 1'b1);
    step();
    n_vec++;
    if (bus.m_valid_o !== 3'b001 || bus.m_data_o[0] !== 8'h61) begin
      n_err++; $display("FAIL b2b_first: got v=%b d=%h expected v=001 d=61",
                        bus.m_valid_o, bus.m_data_o[0]);
    end
    drive(2'd1, 8'h62, 4'd6, 1'b1);
    step();
    n_vec++;
    if (bus.m_valid_o !== 3'b010 || bus.m_data_o[1] !== 8'h62 || bus.m_qos_o[1] !== 4'd6) begin
      n_err++; $display("FAIL b2b_second: got v=%b d=%h q=%h expected v=010 d=62 q=6",
                        bus.m_valid_o, bus.m_data_o[1], bus.m_qos_o[1]);
    end
    idle();
    step();
    n_vec++;
    if (bus.m_valid_o !== 3'b000) begin
      n_err++; $display("FAIL b2b_drained: got %b expected 000", bus.m_valid_o);
    end
  endtask

  task automatic test_async_reset();
    bus.m_ready_i = 3'b111;
    drive(2'd1, 8'h71, 4'd2, 1'b0);
    step();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.m_valid_o !== 3'b000 || drop_cnt !== 3'd0) begin
      n_err++; $display("FAIL areset_clear: got v=%b cnt=%0d expected v=000 cnt=0",
                        bus.m_valid_o, drop_cnt);
    end
    step();
    rst_n = 1'b1;
    drive(2'd2, 8'h72, 4'd9, 1'b1);
    step();
    n_vec++;
    if (bus.m_valid_o !== 3'b100 || bus.m_data_o[2] !== 8'h72) begin
      n_err++; $display("FAIL areset_head: got v=%b d=%h expected v=100 d=72",
                        bus.m_valid_o, bus.m_data_o[2]);
    end
    idle();
    step();
  endtask

  initial begin
    idle();
    bus.m_ready_i = '0;
    test_reset();
    test_single_packet();
    test_backpressure();
    test_route_lock();
    test_invalid_id();
    test_drop_saturate();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
